// File: rtl/mc_core_if.sv
// Instruction/data memory handshake bundle for mc_core.
// master: the core (drives requests), slave: the memories (drive acks and read data).
interface mc_core_if #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 12
);
  logic         imem_req;
  logic [D-1:0] imem_addr;
  logic         imem_ack;
  logic [8:0]   imem_data;
  logic         dmem_req;
  logic         dmem_we;
  logic [W-1:0] dmem_addr;
  logic [W-1:0] dmem_wdata;
  logic         dmem_ack;
  logic [W-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_data, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_data, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mc_core.sv
// Multi-cycle 9-bit-ISA core: FETCH/EXEC/MEM sequencing over req/ack memories,
// 8-entry register file, Z/C flags, halts when the PC reaches DONE_PC.
// Optional feature macro: CORE_PERF_EN (cycle and retired-instruction counters).
module mc_core #(
  parameter int unsigned W       = 8,
  parameter int unsigned D       = 12,
  parameter int unsigned DONE_PC = 128
) (
  input  logic        clk,
  input  logic        reset,
  mc_core_if.master   bus,
  output logic        done,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [2:0]   OP_ADD = 3'd0;
  localparam logic [2:0]   OP_SUB = 3'd1;
  localparam logic [2:0]   OP_AND = 3'd2;
  localparam logic [2:0]   OP_XOR = 3'd3;
  localparam logic [2:0]   OP_SHL = 3'd4;
  localparam logic [2:0]   OP_LD  = 3'd5;
  localparam logic [2:0]   OP_ST  = 3'd6;
  localparam logic [2:0]   OP_BRZ = 3'd7;
  localparam logic [D-1:0] DONE_ADDR = D'(DONE_PC);

  state_t       state;
  logic [D-1:0] pc;
  logic [8:0]   ir;
  logic         z_flag;
  logic         c_flag;
  logic [W-1:0] rf [8];

  logic [2:0]   op;
  logic [2:0]   ra;
  logic [2:0]   rb;
  logic [W-1:0] ra_val;
  logic [W-1:0] rb_val;
  logic         is_mem;
  logic [D-1:0] next_pc;
  logic         halt_next;
  logic [W:0]   sum_w;
  logic [W-1:0] alu_res;
  logic         alu_c;

  assign op     = ir[8:6];
  assign ra     = ir[5:3];
  assign rb     = ir[2:0];
  assign ra_val = rf[ra];
  assign rb_val = rf[rb];
  assign is_mem = (op == OP_LD) || (op == OP_ST);

  assign bus.imem_addr = pc;

  // PC of the next instruction; a taken branch only exists in EXEC
  always_comb begin
    next_pc = pc + D'(1);
    if (state == S_EXEC && op == OP_BRZ && z_flag)
      next_pc = pc + {{(D-6){ir[5]}}, ir[5:0]};
    halt_next = (next_pc == DONE_ADDR);
  end

  // ALU result and carry; AND/XOR keep the current carry
  always_comb begin
    sum_w   = '0;
    alu_res = '0;
    alu_c   = c_flag;
    case (op)
      OP_ADD: begin
        sum_w   = {1'b0, ra_val} + {1'b0, rb_val};
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
      end
      OP_SUB: begin
        sum_w   = {1'b0, ra_val} - {1'b0, rb_val};
        alu_res = sum_w[W-1:0];
        alu_c   = ~sum_w[W];
      end
      OP_AND: alu_res = ra_val & rb_val;
      OP_XOR: alu_res = ra_val ^ rb_val;
      OP_SHL: begin
        alu_res = {ra_val[W-2:0], c_flag};
        alu_c   = ra_val[W-1];
      end
      default: ;
    endcase
  end

  // Sequencer, architectural state and registered bus outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_FETCH;
      pc             <= '0;
      ir             <= '0;
      z_flag         <= 1'b0;
      c_flag         <= 1'b0;
      done           <= 1'b0;
      bus.imem_req   <= 1'b0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          // First FETCH after reset: request not yet raised, apply the halt check
          if (!bus.imem_req) begin
            if (pc == DONE_ADDR) begin
              state <= S_HALT;
              done  <= 1'b1;
            end else begin
              bus.imem_req <= 1'b1;
            end
          end else if (bus.imem_ack) begin
            ir           <= bus.imem_data;
            bus.imem_req <= 1'b0;
            state        <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_mem) begin
            state          <= S_MEM;
            bus.dmem_req   <= 1'b1;
            bus.dmem_we    <= (op == OP_ST);
            bus.dmem_addr  <= rb_val;
            bus.dmem_wdata <= ra_val;
          end else begin
            if (op != OP_BRZ) begin
              rf[ra] <= alu_res;
              z_flag <= (alu_res == '0);
              c_flag <= alu_c;
            end
            pc <= next_pc;
            if (halt_next) begin
              state <= S_HALT;
              done  <= 1'b1;
            end else begin
              state        <= S_FETCH;
              bus.imem_req <= 1'b1;
            end
          end
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            bus.dmem_req <= 1'b0;
            bus.dmem_we  <= 1'b0;
            if (!bus.dmem_we) begin
              rf[ra] <= bus.dmem_rdata;
              z_flag <= (bus.dmem_rdata == '0);
            end
            pc <= next_pc;
            if (halt_next) begin
              state <= S_HALT;
              done  <= 1'b1;
            end else begin
              state        <= S_FETCH;
              bus.imem_req <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CORE_PERF_EN
  logic cyc_inc;
  logic ret_inc;

  // The idle post-reset FETCH cycle is not counted
  assign cyc_inc = (state != S_HALT) && !(state == S_FETCH && !bus.imem_req);
  assign ret_inc = (state == S_EXEC && !is_mem) || (state == S_MEM && bus.dmem_ack);

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (cyc_inc && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
      if (ret_inc && ret_cnt != '1) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule
